// File: rtl/store_lane_packer_pkg.sv
// Shared definitions for the store lane packer: op encoding, buffered entry
// layout and the byte-lane packing/alignment helpers.
package store_lane_packer_pkg;

   localparam logic [1:0] OP_SW = 2'd0;
   localparam logic [1:0] OP_SH = 2'd1;
   localparam logic [1:0] OP_SB = 2'd2;

   // addr is carried at 32 bits; narrower ADDR_W values are zero-extended
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } entry_t;

   typedef struct packed {
      logic [31:0] wdata;
      logic [3:0]  be;
   } lanes_t;

   // Reserved op 3 falls through to word packing
   function automatic lanes_t pack_lanes(input logic [1:0] op, input logic [1:0] addr,
                                         input logic [31:0] data);
      lanes_t l;
      case (op)
         OP_SB:   begin l.be = 4'b0001 << addr; l.wdata = {4{data[7:0]}}; end
         OP_SH:   begin l.be = addr[1] ? 4'b1100 : 4'b0011; l.wdata = {2{data[15:0]}}; end
         default: begin l.be = 4'b1111; l.wdata = data; end
      endcase
      return l;
   endfunction

   function automatic logic misaligned(input logic [1:0] op, input logic [1:0] addr);
      logic m;
      case (op)
         OP_SW:   m = (addr != 2'b00);
         OP_SH:   m = addr[0];
         OP_SB:   m = 1'b0;
         default: m = 1'b1;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/store_lane_packer_fifo.sv
// store_fifo: generic DEPTH-entry synchronous FIFO with occupancy count.
// Head data is read combinationally from the storage array.
module store_fifo #(
   parameter int W     = 68,
   parameter int DEPTH = 2,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/store_lane_packer.sv
// Store lane packer + write buffer toward data memory.
// Optional macro ALIGN_CHK_EN: drop misaligned stores and pulse align_err.
module store_lane_packer
   import store_lane_packer_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [1:0]               req_op,
   input  logic [ADDR_W-1:0]        req_addr,
   input  logic [31:0]              req_data,
   output logic                     mem_valid,
   input  logic                     mem_ready,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [31:0]              mem_wdata,
   output logic [3:0]               mem_be,
   output logic                     align_err,
   output logic [$clog2(DEPTH):0]   count
);

   lanes_t lanes;
   entry_t in_e, head, last_q, shown;
   logic   accept, bad, push, pop, full, empty;

   assign accept = req_valid && req_ready;
   assign lanes  = pack_lanes(req_op, req_addr[1:0], req_data);
`ifdef ALIGN_CHK_EN
   assign bad    = misaligned(req_op, req_addr[1:0]);
`else
   assign bad    = 1'b0;
`endif
   assign push   = accept && !bad;
   assign pop    = mem_valid && mem_ready;

   assign in_e.addr  = 32'({req_addr[ADDR_W-1:2], 2'b00});
   assign in_e.wdata = lanes.wdata;
   assign in_e.be    = lanes.be;

   store_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (in_e),
      .pop   (pop),
      .rdata (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   assign req_ready = !full;
   assign mem_valid = !empty;

   // Keep the last presented entry on mem_* once the buffer runs dry
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_q    <= '0;
         align_err <= 1'b0;
      end else begin
         if (pop) last_q <= head;
         align_err <= accept && bad;
      end
   end

   assign shown     = empty ? last_q : head;
   assign mem_addr  = ADDR_W'(shown.addr);
   assign mem_wdata = shown.wdata;
   assign mem_be    = shown.be;

endmodule

// File: tb/tb_store_lane_packer.sv
// Bench for store_lane_packer: vector table plus hand sequences for
// backpressure, misalignment, push/pop wrap and reset mid-operation.
module tb_store_lane_packer;
   import store_lane_packer_pkg::*;

   localparam int DEPTH  = 2;
   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid, req_ready, mem_valid, mem_ready, align_err;
   logic [1:0]        req_op;
   logic [ADDR_W-1:0] req_addr, mem_addr;
   logic [31:0]       req_data, mem_wdata;
   logic [3:0]        mem_be;
   logic [$clog2(DEPTH):0] count;

   store_lane_packer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .align_err(align_err), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] ea;
      logic [3:0]  ebe;
      logic [31:0] ewd;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } exp_t;

   exp_t sb[$];
   int tests = 0, fails = 0, mtests = 0, mfails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      tests++;
      fails++;
      $display("FAIL %s: timed out", name);
   endtask

   // Scoreboard pop on every handshake, plus stability check while stalled
   logic        p_stall = 1'b0;
   logic [31:0] p_addr, p_wdata;
   logic [3:0]  p_be;
   always @(negedge clk) begin
      if (!reset) begin
         p_stall = 1'b0;
      end else begin
         if (p_stall) begin
            mtests++;
            if ({mem_addr, mem_wdata, mem_be} !== {p_addr, p_wdata, p_be}) begin
               mfails++;
               $display("FAIL stall_stable: got %h/%h/%h expected %h/%h/%h",
                        mem_addr, mem_wdata, mem_be, p_addr, p_wdata, p_be);
            end
         end
         if (mem_valid && mem_ready) begin
            mtests++;
            if (sb.size() == 0) begin
               mfails++;
               $display("FAIL unexpected_pop: got addr %h with nothing expected", mem_addr);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (mem_addr !== e.addr || mem_wdata !== e.wdata || mem_be !== e.be) begin
                  mfails++;
                  $display("FAIL pop_entry: got %h/%h/%h expected %h/%h/%h",
                           mem_addr, mem_wdata, mem_be, e.addr, e.wdata, e.be);
               end
            end
         end
         p_stall = mem_valid && !mem_ready;
         p_addr  = mem_addr;
         p_wdata = mem_wdata;
         p_be    = mem_be;
      end
   end

   task automatic send(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic exp_push, input logic [31:0] ea, input logic [31:0] ewd,
                       input logic [3:0] ebe);
      bit done = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = op; req_addr = addr; req_data = data;
      if (exp_push) sb.push_back('{ea, ewd, ebe});
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (req_ready) done = 1;
         @(posedge clk);
      end
      #1 req_valid = 1'b0;
      if (!done) timeout("send_accept");
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
      chk(name, sb.size(), 0);
   endtask

   vec_t vecs[7];
   bit   ok;

   initial begin
      vecs[0] = '{OP_SB, 32'h0000_1003, 32'h0000_00A5, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5};
      vecs[1] = '{OP_SH, 32'h0000_2002, 32'hFFFF_1234, 32'h0000_2000, 4'b1100, 32'h1234_1234};
      vecs[2] = '{OP_SW, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF};
      vecs[3] = '{OP_SB, 32'h0000_0005, 32'h1234_5678, 32'h0000_0004, 4'b0010, 32'h7878_7878};
      vecs[4] = '{OP_SB, 32'h0000_0006, 32'h0000_00CC, 32'h0000_0004, 4'b0100, 32'hCCCC_CCCC};
      vecs[5] = '{OP_SH, 32'h0000_0008, 32'hABCD_5555, 32'h0000_0008, 4'b0011, 32'h5555_5555};
      vecs[6] = '{OP_SW, 32'hFFFF_FFFC, 32'h0102_0304, 32'hFFFF_FFFC, 4'b1111, 32'h0102_0304};

      reset = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_data = '0; mem_ready = 1'b0;
      #22;
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_req_ready", req_ready, 1);
      @(negedge clk); #2 reset = 1'b1;
      @(negedge clk);
      chk("rst_count", count, 0);
      chk("rst_align_err", align_err, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_be", mem_be, 0);

      // Table: each store enters an empty buffer and must show up one cycle later
      mem_ready = 1'b1;
      foreach (vecs[i]) begin
         send(vecs[i].op, vecs[i].addr, vecs[i].data, 1'b1, vecs[i].ea, vecs[i].ewd, vecs[i].ebe);
         @(negedge clk);
         chk("lat_mem_valid", mem_valid, 1);
         chk("lat_count", count, 1);
         chk("lat_mem_addr", mem_addr, vecs[i].ea);
         chk("lat_mem_be", mem_be, vecs[i].ebe);
         chk("lat_mem_wdata", mem_wdata, vecs[i].ewd);
      end
      drain("table_drain");

      // Backpressure: two fill the buffer, the third waits
      @(posedge clk); #1 mem_ready = 1'b0;
      send(OP_SW, 32'h0, 32'h1111_1111, 1'b1, 32'h0, 32'h1111_1111, 4'hF);
      send(OP_SW, 32'h4, 32'h2222_2222, 1'b1, 32'h4, 32'h2222_2222, 4'hF);
      @(negedge clk);
      chk("bp_count", count, 2);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_head_addr", mem_addr, 32'h0);
      #2;
      req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h8; req_data = 32'h3333_3333;
      sb.push_back('{32'h8, 32'h3333_3333, 4'hF});
      repeat (2) begin
         @(negedge clk);
         chk("bp_hold_ready", req_ready, 0);
         chk("bp_hold_count", count, 2);
      end
      @(posedge clk); #1 mem_ready = 1'b1;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (req_ready) ok = 1;
         @(posedge clk);
      end
      #1 req_valid = 1'b0;
      if (!ok) timeout("bp_third_accept");
      drain("bp_drain");

      // Misaligned word and reserved op
`ifdef ALIGN_CHK_EN
      send(OP_SW, 32'h3001, 32'hCAFE_F00D, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      chk("mis_align_err", align_err, 1);
      chk("mis_count", count, 0);
      chk("mis_mem_valid", mem_valid, 0);
      @(negedge clk);
      chk("mis_err_pulse", align_err, 0);
      send(2'd3, 32'h3000, 32'h1, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      chk("op3_align_err", align_err, 1);
      chk("op3_mem_valid", mem_valid, 0);
`else
      send(OP_SW, 32'h3001, 32'hCAFE_F00D, 1'b1, 32'h3000, 32'hCAFE_F00D, 4'hF);
      @(negedge clk);
      chk("mis_mem_valid", mem_valid, 1);
      chk("mis_mem_be", mem_be, 4'hF);
      chk("mis_align_err", align_err, 0);
      send(2'd3, 32'h3006, 32'h0BAD_0BAD, 1'b1, 32'h3004, 32'h0BAD_0BAD, 4'hF);
      @(negedge clk);
      chk("op3_mem_be", mem_be, 4'hF);
      chk("op3_align_err", align_err, 0);
`endif
      drain("mis_drain");

      // Push and pop together at count=1, running past pointer wrap
      @(posedge clk); #1 mem_ready = 1'b0;
      send(OP_SW, 32'h100, 32'hA000_0000, 1'b1, 32'h100, 32'hA000_0000, 4'hF);
      mem_ready = 1'b1;
      for (int k = 0; k < 2*DEPTH + 2; k++) begin
         req_valid = 1'b1; req_op = OP_SB; req_addr = 32'h104 + 32'(k*4) + 32'(k%4);
         req_data = 32'(k + 1);
         sb.push_back('{32'h104 + 32'(k*4), {4{8'(k + 1)}}, 4'b0001 << (k%4)});
         @(negedge clk);
         chk("pp_count", count, 1);
         chk("pp_req_ready", req_ready, 1);
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      @(negedge clk);
      chk("pp_tail_count", count, 1);
      drain("pp_drain");
      chk("pp_empty_count", count, 0);

      // Reset with a full, stalled buffer
      @(posedge clk); #1 mem_ready = 1'b0;
      send(OP_SW, 32'h200, 32'h5, 1'b1, 32'h200, 32'h5, 4'hF);
      send(OP_SW, 32'h204, 32'h6, 1'b1, 32'h204, 32'h6, 4'hF);
      @(negedge clk);
      chk("mid_count", count, 2);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_valid", mem_valid, 0);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_ready", req_ready, 1);
      chk("mid_rst_addr", mem_addr, 0);
      chk("mid_rst_be", mem_be, 0);
      chk("mid_rst_wdata", mem_wdata, 0);
      sb.delete();
      @(negedge clk); #2 reset = 1'b1; mem_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("post_rst_valid", mem_valid, 0);
      end
      send(OP_SH, 32'h0000_0402, 32'h0000_BEEF, 1'b1, 32'h400, 32'hBEEF_BEEF, 4'b1100);
      drain("final_drain");

      repeat (2) @(negedge clk);
      tests += mtests;
      fails += mfails;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
